// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage.
// Option macro: IFU_MISALIGN_TRAP_EN (misaligned redirect trap).
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP_INSTR  = 32'h0000_0013;
  localparam word_t HALT_INSTR = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_RUN  = 2'd1,
    IFU_HALT = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ROM bus plus decode handshake seen by the fetch stage.
// Option macro: IFU_MISALIGN_TRAP_EN adds misalign_fault.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  word_t rom_addr;
  logic  rom_en;
  word_t rom_data;

  logic  stall;
  logic  redirect_valid;
  word_t redirect_pc;

  word_t instr;
  word_t instr_pc;
  logic  instr_valid;
  logic  instr_ready;
  logic  halted;
`ifdef IFU_MISALIGN_TRAP_EN
  logic  misalign_fault;
`endif

  modport master (
    output rom_addr,
    output rom_en,
    input  rom_data,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    output halted
`ifdef IFU_MISALIGN_TRAP_EN
    , output misalign_fault
`endif
  );

  modport slave (
    input  rom_addr,
    input  rom_en,
    output rom_data,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    input  halted
`ifdef IFU_MISALIGN_TRAP_EN
    , input misalign_fault
`endif
  );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with redirect / +4 / hold next-PC mux.
// Wraps modulo 2^32; no overflow indication.
module ifu_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  ld_redirect,
  input  logic  ld_inc,
  input  word_t redirect_pc,
  output word_t pc
);

  word_t pc_nxt;

  always_comb begin
    pc_nxt = pc;
    unique case (1'b1)
      ld_redirect: pc_nxt = redirect_pc;
      ld_inc:      pc_nxt = pc + 32'd4;
      default:     pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= RESET_PC;
    else          pc <= pc_nxt;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: FSM, one-entry instruction buffer, ROM drive.
// Option macro: IFU_MISALIGN_TRAP_EN traps misaligned redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t HALT_WORD = HALT_INSTR
) (
  input logic clk,
  input logic reset_n,
  instr_fetch_unit_if.master bus
);

  ifu_state_e state_q, state_d;
  word_t      pc;
  word_t      instr_q, instr_d;
  word_t      ipc_q, ipc_d;
  logic       valid_q, valid_d;
  logic       ld_redir, ld_inc;
  logic       accept, can_load, is_halt;
`ifdef IFU_MISALIGN_TRAP_EN
  logic       fault_q, fault_d;
`endif

  assign accept   = valid_q & bus.instr_ready;
  assign can_load = ~valid_q | bus.instr_ready;
  assign is_halt  = (bus.rom_data == HALT_WORD);

  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .reset_n     (reset_n),
    .ld_redirect (ld_redir),
    .ld_inc      (ld_inc),
    .redirect_pc (bus.redirect_pc),
    .pc          (pc)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    ld_redir = 1'b0;
    ld_inc   = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    fault_d  = fault_q;
`endif
    unique case (state_q)
      IFU_IDLE: state_d = IFU_RUN;
      IFU_RUN: begin
        // redirect outranks stall, which outranks loading
        if (bus.redirect_valid) begin
          valid_d = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
          if (bus.redirect_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = IFU_HALT;
          end else begin
            ld_redir = 1'b1;
          end
`else
          ld_redir = 1'b1;
`endif
        end else if (bus.stall) begin
          valid_d = valid_q;
        end else if (can_load && !is_halt) begin
          instr_d = bus.rom_data;
          ipc_d   = pc;
          valid_d = 1'b1;
          ld_inc  = 1'b1;
        end else if (can_load) begin
          state_d = IFU_HALT;
          valid_d = accept ? 1'b0 : valid_q;
        end
      end
      IFU_HALT: begin
        if (accept) valid_d = 1'b0;
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IFU_IDLE;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign bus.misalign_fault = fault_q;
`endif

  assign bus.rom_en      = (state_q == IFU_RUN);
  assign bus.rom_addr    = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = (state_q == IFU_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM image, reference model, directed vectors.
// Option macro: IFU_MISALIGN_TRAP_EN selects the trap expectations.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] HALT_W = 32'h7FFF_FFFF;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .HALT_WORD (HALT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Program at 0x0..0x40, one word at the top of memory, halt elsewhere
  function automatic logic [31:0] prog(input logic [31:0] a);
    if (a == 32'hFFFF_FFFC) return 32'hDEAD_0013;
    if (a <= 32'h40 && a[1:0] == 2'b00)
      return 32'h1000_0013 + (a << 8);
    return HALT_W;
  endfunction

  // Disabled ROM returns the halt word, so a stage that ignores rom_en stops
  assign bus.rom_data = bus.rom_en ? prog(bus.rom_addr) : HALT_W;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // Reference model: what the stage holds, from the behavioural rules
  logic        m_run, m_halt, m_fault, m_valid;
  logic [31:0] m_pc, m_instr, m_ipc;

  task automatic model_reset();
    m_run   = 1'b0;
    m_halt  = 1'b0;
    m_fault = 1'b0;
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_instr = NOP_W;
    m_ipc   = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    w = prog(m_pc);
    if (!m_run) begin
      m_run = 1'b1;
    end else if (m_halt) begin
      if (m_valid && bus.instr_ready) m_valid = 1'b0;
    end else if (bus.redirect_valid) begin
      m_valid = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      if (bus.redirect_pc % 4 != 0) begin
        m_halt  = 1'b1;
        m_fault = 1'b1;
      end else
`endif
      m_pc = bus.redirect_pc;
    end else if (!bus.stall && (!m_valid || bus.instr_ready)) begin
      if (w == HALT_W) begin
        m_halt  = 1'b1;
        m_valid = 1'b0;
      end else begin
        m_instr = w;
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (reset_n) model_step();
  end

  initial forever begin
    @(negedge clk);
    chk1("m_rom_en", bus.rom_en, m_run && !m_halt);
    chk("m_rom_addr", bus.rom_addr, m_pc);
    chk1("m_valid", bus.instr_valid, m_valid);
    chk1("m_halted", bus.halted, m_halt);
    if (m_valid) begin
      chk("m_instr", bus.instr, m_instr);
      chk("m_instr_pc", bus.instr_pc, m_ipc);
    end
`ifdef IFU_MISALIGN_TRAP_EN
    chk1("m_fault", bus.misalign_fault, m_fault);
`endif
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  logic [31:0] last;
  logic        found;

  initial begin
    bus.instr_ready    = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    reset_n            = 1'b0;
    model_reset();
    tick(); tick();
    chk1("rst_rom_en", bus.rom_en, 1'b0);
    chk("rst_addr", bus.rom_addr, 32'h0);
    chk("rst_instr", bus.instr, NOP_W);
    chk("rst_ipc", bus.instr_pc, 32'h0);
    chk1("rst_valid", bus.instr_valid, 1'b0);
    chk1("rst_halted", bus.halted, 1'b0);

    // 1: idle cycle then streaming fetch
    reset_n = 1'b1;
    tick();
    chk1("t1_rom_en", bus.rom_en, 1'b1);
    chk1("t1_idle_valid", bus.instr_valid, 1'b0);
    tick();
    chk("t1_ipc0", bus.instr_pc, 32'h0);
    chk("t1_addr4", bus.rom_addr, 32'h4);
    tick();
    chk("t1_ipc4", bus.instr_pc, 32'h4);
    tick();
    chk("t1_ipc8", bus.instr_pc, 32'h8);
    chk("t1_addrC", bus.rom_addr, 32'hC);

    // 2: decode backpressure
    bus.instr_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t2_ipc", bus.instr_pc, 32'h8);
      chk("t2_instr", bus.instr, 32'h1000_0813);
      chk("t2_addr", bus.rom_addr, 32'hC);
    end
    bus.instr_ready = 1'b1;
    tick();
    chk("t2_next", bus.instr_pc, 32'hC);
    tick();
    chk("t2_addr14", bus.rom_addr, 32'h14);

    // 3: redirect beats stall
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    bus.stall          = 1'b1;
    tick();
    chk1("t3_flush", bus.instr_valid, 1'b0);
    chk("t3_addr", bus.rom_addr, 32'h20);
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    tick();
    chk("t3_ipc", bus.instr_pc, 32'h20);

    // plain stall freezes everything
    bus.stall       = 1'b1;
    bus.instr_ready = 1'b0;
    tick(); tick();
    chk("st_ipc", bus.instr_pc, 32'h20);
    chk("st_addr", bus.rom_addr, 32'h24);
    bus.stall       = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    chk("st_next", bus.instr_pc, 32'h24);

    // PC wraps from the top of memory
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    chk("wr_addr", bus.rom_addr, 32'hFFFF_FFFC);
    bus.redirect_valid = 1'b0;
    tick();
    chk("wr_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    chk("wr_instr", bus.instr, 32'hDEAD_0013);
    chk("wr_addr0", bus.rom_addr, 32'h0);

    // 4: run into the halt word
    last  = 32'h0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.instr_valid) last = bus.instr_pc;
      tick();
      if (bus.halted) begin
        found = 1'b1;
        break;
      end
    end
    chk1("t4_halt_seen", found, 1'b1);
    chk("t4_last_ipc", last, 32'h40);
    chk1("t4_rom_en", bus.rom_en, 1'b0);
    chk1("t4_valid", bus.instr_valid, 1'b0);
    chk("t4_addr", bus.rom_addr, 32'h44);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8;
    bus.stall          = 1'b1;
    tick(); tick();
    chk("t4_ign_addr", bus.rom_addr, 32'h44);
    chk1("t4_ign_halt", bus.halted, 1'b1);
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;

    // 5: asynchronous reset between edges
    reset_n = 1'b0;
    model_reset();
    tick();
    reset_n = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    tick(); tick();
    chk1("t5_pre_valid", bus.instr_valid, 1'b1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk1("t5_valid", bus.instr_valid, 1'b0);
    chk("t5_addr", bus.rom_addr, 32'h0);
    chk1("t5_rom_en", bus.rom_en, 1'b0);
    chk("t5_instr", bus.instr, NOP_W);
    chk("t5_ipc", bus.instr_pc, 32'h0);
    chk1("t5_halted", bus.halted, 1'b0);
    tick();
    reset_n         = 1'b1;
    bus.instr_ready = 1'b1;
    tick(); tick(); tick();
    chk("t6_pre_ipc", bus.instr_pc, 32'h4);
    chk("t6_pre_addr", bus.rom_addr, 32'h8);

    // 6: misaligned redirect
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h22;
    tick();
    bus.redirect_valid = 1'b0;
    chk1("t6_valid", bus.instr_valid, 1'b0);
`ifdef IFU_MISALIGN_TRAP_EN
    chk1("t6_fault", bus.misalign_fault, 1'b1);
    chk1("t6_halted", bus.halted, 1'b1);
    chk("t6_addr", bus.rom_addr, 32'h8);
`else
    chk("t6_addr", bus.rom_addr, 32'h22);
    tick();
    chk1("t6_halted", bus.halted, 1'b1);
`endif
    tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
